// File: rtl/instr_buffer_pkg.sv
// Shared configuration and entry types for the fetch-to-decode instruction buffer.
// The default configuration matches a 4-wide fetch, 4-wide decode, 16-slot buffer.
package instr_buffer_pkg;

  localparam int VLEN        = 32;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned FETCH_WIDTH;
    int unsigned DECODE_WIDTH;
    int unsigned IBUF_DEPTH;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{
    VLEN:         32,
    FETCH_WIDTH:  4,
    DECODE_WIDTH: 4,
    IBUF_DEPTH:   16
  };

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ibuf_entry_t;

endpackage

// File: rtl/instr_buffer.sv
// Circular fetch-to-decode queue: accepts one fetch group per cycle and presents up
// to DECODE_WIDTH oldest instructions (with PCs) to decode, combinationally from head.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter cfg_t Cfg          = EmptyCfg,
  parameter int   DECODE_WIDTH = int'(Cfg.DECODE_WIDTH),
  parameter int   DEPTH        = int'(Cfg.IBUF_DEPTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                fe_valid_i,
  output logic                                fe_ready_o,
  input  logic [Cfg.VLEN-1:0]                 fe_pc_i,
  input  logic [$clog2(Cfg.FETCH_WIDTH):0]    fe_cnt_i,
  input  logic [Cfg.FETCH_WIDTH*ILEN-1:0]     fe_instr_i,
  output logic [DECODE_WIDTH-1:0]             de_valid_o,
  output logic [DECODE_WIDTH*Cfg.VLEN-1:0]    de_pc_o,
  output logic [DECODE_WIDTH*ILEN-1:0]        de_instr_o,
  input  logic                                de_ready_i
);

  localparam int VL = int'(Cfg.VLEN);
  localparam int FW = int'(Cfg.FETCH_WIDTH);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(FW) + 1;
  localparam int SW = (FW > 1) ? $clog2(FW) : 1;

  typedef struct packed {
    logic [VL-1:0]   pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  entry_t          mem       [DEPTH];
  entry_t          in_entry  [FW];
  logic [SW-1:0]   slot_sel  [DEPTH];
  logic [IW-1:0]   rd_idx    [DECODE_WIDTH];
  logic [DEPTH-1:0] slot_we;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] count;
  logic [PW-1:0] free_slots;
  logic [PW-1:0] pop_cnt;
  logic          push;
  logic          pop;

  // Pointers carry a wrap bit, so tail - head is the occupancy even when full.
  assign count      = tail - head;
  assign free_slots = PW'(DEPTH) - count;
  assign fe_ready_o = free_slots >= PW'(FW);
  assign push       = fe_valid_i && fe_ready_o && !flush_i;
  assign pop        = de_ready_i && !flush_i;
  assign pop_cnt    = (count > PW'(DECODE_WIDTH)) ? PW'(DECODE_WIDTH) : count;

  always_comb begin
    for (int i = 0; i < FW; i++) begin
      in_entry[i].pc    = fe_pc_i + VL'(INSTR_BYTES * i);
      in_entry[i].instr = fe_instr_i[i*ILEN +: ILEN];
    end
  end

  // Each storage slot works out which incoming lane (if any) lands on it this cycle.
  always_comb begin
    slot_we = '0;
    for (int s = 0; s < DEPTH; s++) begin
      slot_sel[s] = '0;
      for (int i = 0; i < FW; i++) begin
        if (push && (CW'(i) < fe_cnt_i) &&
            ((tail[IW-1:0] + IW'(i)) == IW'(s))) begin
          slot_we[s]  = 1'b1;
          slot_sel[s] = SW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (slot_we[s]) begin
        mem[s] <= in_entry[slot_sel[s]];
      end
    end
  end

  always_comb begin
    de_valid_o = '0;
    de_pc_o    = '0;
    de_instr_o = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      rd_idx[k]                 = head[IW-1:0] + IW'(k);
      de_valid_o[k]             = PW'(k) < count;
      de_pc_o[k*VL +: VL]       = mem[rd_idx[k]].pc;
      de_instr_o[k*ILEN +: ILEN] = mem[rd_idx[k]].instr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head <= '0;
      tail <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(fe_cnt_i);
      end
      if (pop) begin
        head <= head + pop_cnt;
      end
    end
  end

  // Upstream must never hand over an empty group, and a push must always fit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count <= PW'(DEPTH));
      if (fe_valid_i) begin
        assert (fe_cnt_i != '0 && fe_cnt_i <= CW'(FW));
      end
      if (push) begin
        assert (int'(count) + int'(fe_cnt_i) <= DEPTH);
      end
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: a queue model checked every cycle, directed scenarios with
// hand-computed expectations, then randomized traffic with stalls and flushes.
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int FW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         feValid;
  logic         feReady;
  logic [31:0]  fePc;
  logic [2:0]   feCnt;
  logic [127:0] feInstr;
  logic [3:0]   deValid;
  logic [127:0] dePc;
  logic [127:0] deInstr;
  logic         deReady;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] qPc[$];
  logic [31:0] qInstr[$];
  int          mSize;
  int          mPop;

  instr_buffer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .fe_valid_i (feValid),
    .fe_ready_o (feReady),
    .fe_pc_i    (fePc),
    .fe_cnt_i   (feCnt),
    .fe_instr_i (feInstr),
    .de_valid_o (deValid),
    .de_pc_o    (dePc),
    .de_instr_o (deInstr),
    .de_ready_i (deReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; instruction for lane i is instrBase + i.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [2:0] cnt,
                               input logic [31:0] instrBase, input logic rdy, input logic fl);
    feValid = v;
    fePc    = pc;
    feCnt   = cnt;
    for (int i = 0; i < FW; i++) feInstr[i*32 +: 32] = instrBase + 32'(i);
    deReady = rdy;
    flush   = fl;
    @(posedge clk);
    #1;
    feValid = 1'b0;
    deReady = 1'b0;
    flush   = 1'b0;
  endtask

  // Model: in-order queue; outputs compared before each edge, then the edge applied.
  always @(negedge clk) begin
    if (rst) begin
      qPc.delete();
      qInstr.delete();
    end else begin
      mSize = qPc.size();
      checkOutput("fe_ready", 32'(feReady), 32'((DEPTH - mSize) >= FW));
      for (int k = 0; k < DW; k++) begin
        checkOutput($sformatf("de_valid[%0d]", k), 32'(deValid[k]), 32'(k < mSize));
        if (k < mSize) begin
          checkOutput($sformatf("de_pc[%0d]", k), dePc[k*32 +: 32], qPc[k]);
          checkOutput($sformatf("de_instr[%0d]", k), deInstr[k*32 +: 32], qInstr[k]);
        end
      end
      if (flush) begin
        qPc.delete();
        qInstr.delete();
      end else begin
        mPop = deReady ? ((mSize < DW) ? mSize : DW) : 0;
        for (int k = 0; k < mPop; k++) begin
          void'(qPc.pop_front());
          void'(qInstr.pop_front());
        end
        if (feValid && ((DEPTH - mSize) >= FW)) begin
          for (int i = 0; i < int'(feCnt); i++) begin
            qPc.push_back(fePc + 32'(4 * i));
            qInstr.push_back(feInstr[i*32 +: 32]);
          end
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    feValid = 1'b0;
    fePc    = '0;
    feCnt   = 3'd1;
    feInstr = '0;
    deReady = 1'b0;
    #2;
    checkOutput("reset de_valid", 32'(deValid), 32'h0);
    checkOutput("reset fe_ready", 32'(feReady), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single full group becomes visible the next cycle.
    applyStimulus(1'b1, 32'h8000_0000, 3'd4, 32'hA0, 1'b0, 1'b0);
    #1;
    checkOutput("grp de_valid", 32'(deValid), 32'hF);
    checkOutput("grp pc0", dePc[31:0],   32'h8000_0000);
    checkOutput("grp pc1", dePc[63:32],  32'h8000_0004);
    checkOutput("grp pc2", dePc[95:64],  32'h8000_0008);
    checkOutput("grp pc3", dePc[127:96], 32'h8000_000C);
    checkOutput("grp instr3", deInstr[127:96], 32'hA3);

    // Fill to 16, then a single pop frees a group slot.
    applyStimulus(1'b1, 32'h1000, 3'd4, 32'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1010, 3'd4, 32'hC0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1020, 3'd4, 32'hD0, 1'b0, 1'b0);
    #1;
    checkOutput("full fe_ready", 32'(feReady), 32'h0);
    applyStimulus(1'b0, 32'h0, 3'd1, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("after pop fe_ready", 32'(feReady), 32'h1);
    checkOutput("after pop pc0", dePc[31:0], 32'h1000);

    // Drain, then a partial group of 3 is popped in one go.
    repeat (3) applyStimulus(1'b0, 32'h0, 3'd1, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("drained de_valid", 32'(deValid), 32'h0);
    applyStimulus(1'b1, 32'h100, 3'd3, 32'hE0, 1'b0, 1'b0);
    #1;
    checkOutput("partial de_valid", 32'(deValid), 32'h7);
    applyStimulus(1'b0, 32'h0, 3'd1, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("partial popped", 32'(deValid), 32'h0);

    // Pointers are at 19; move both to index 14 then push across the wrap.
    applyStimulus(1'b1, 32'h4000, 3'd4, 32'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4010, 3'd4, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4020, 3'd3, 32'h30, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 3'd1, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h200, 3'd4, 32'hF0, 1'b0, 1'b0);
    #1;
    checkOutput("wrap pc0", dePc[31:0],   32'h200);
    checkOutput("wrap pc2", dePc[95:64],  32'h208);
    checkOutput("wrap pc3", dePc[127:96], 32'h20C);
    checkOutput("wrap instr3", deInstr[127:96], 32'hF3);
    applyStimulus(1'b0, 32'h0, 3'd1, 32'h0, 1'b1, 1'b0);

    // Flush with a simultaneous push and pop keeps nothing.
    applyStimulus(1'b1, 32'h500, 3'd4, 32'h50, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h510, 3'd4, 32'h60, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h520, 3'd1, 32'h70, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h300, 3'd4, 32'h80, 1'b1, 1'b1);
    #1;
    checkOutput("flush de_valid", 32'(deValid), 32'h0);
    checkOutput("flush fe_ready", 32'(feReady), 32'h1);
    applyStimulus(1'b0, 32'h0, 3'd1, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("flush retained", 32'(deValid), 32'h0);

    // Asynchronous reset with 10 entries stored clears the outputs at once.
    applyStimulus(1'b1, 32'h600, 3'd4, 32'h90, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h610, 3'd4, 32'h94, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h620, 3'd2, 32'h98, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrun reset de_valid", 32'(deValid), 32'h0);
    checkOutput("midrun reset fe_ready", 32'(feReady), 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic with stalls and occasional flushes.
    for (int n = 0; n < 3000; n++) begin
      feValid = ($urandom_range(0, 3) != 0);
      fePc    = $urandom;
      feCnt   = 3'($urandom_range(1, 4));
      for (int i = 0; i < FW; i++) feInstr[i*32 +: 32] = $urandom;
      deReady = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 40) == 0);
      @(posedge clk);
      #1;
    end
    feValid = 1'b0;
    deReady = 1'b0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
